// File: rtl/hash_sel_pkg.sv
// Shared defaults and index-width helper for the hashtable bucket selector.
// Used by hash_bucket_select_pipe and bucket_line_reduce.
package hash_sel_pkg;

  localparam int DEF_DATA_LINES   = 4;
  localparam int DEF_BUCKET_SIZE  = 1;
  localparam int DEF_BUCKET_WIDTH = 16;
  localparam int DEF_CNT_WIDTH    = 16;

  // A single line or slot still needs a 1-bit index, which is always 0.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hash_bucket_select_pipe_line_reduce.sv
// Per-line bucket reduction: masked entry, hit, lowest set slot, multi flag.
// HASH_BUCKET_MULTIHIT_CHECK_EN selects priority pick and adds the multi output.
module bucket_line_reduce
  import hash_sel_pkg::*;
#(
  parameter int BUCKET_SIZE  = DEF_BUCKET_SIZE,
  parameter int BUCKET_WIDTH = DEF_BUCKET_WIDTH
) (
  input  logic [BUCKET_SIZE-1:0][BUCKET_WIDTH-1:0] slots,
  input  logic [BUCKET_SIZE-1:0]                   sel,
  output logic [BUCKET_WIDTH-1:0]                  entry,
  output logic                                     hit,
`ifdef HASH_BUCKET_MULTIHIT_CHECK_EN
  output logic                                     multi,
`endif
  output logic [idx_w(BUCKET_SIZE)-1:0]            slot
);

  localparam int SW = idx_w(BUCKET_SIZE);

  assign hit = |sel;

`ifdef HASH_BUCKET_MULTIHIT_CHECK_EN
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(sel & (sel - BUCKET_SIZE'(1)));
`endif

  always_comb begin
    entry = '0;
    slot  = '0;
    // Scan high to low so the lowest set slot is written last and wins.
    for (int i = BUCKET_SIZE - 1; i >= 0; i--) begin
      if (sel[i]) begin
        slot = SW'(i);
`ifdef HASH_BUCKET_MULTIHIT_CHECK_EN
        entry = slots[i];
`endif
      end
    end
`ifndef HASH_BUCKET_MULTIHIT_CHECK_EN
    for (int i = 0; i < BUCKET_SIZE; i++) begin
      entry = entry | (slots[i] & {BUCKET_WIDTH{sel[i]}});
    end
`endif
  end

endmodule

// File: rtl/hash_bucket_select_pipe.sv
// Two-stage handshaked bucket-entry selector for the hashtable read path.
// HASH_BUCKET_MULTIHIT_CHECK_EN: priority pick, multi-hit flag and counter.
module hash_bucket_select_pipe
  import hash_sel_pkg::*;
#(
  parameter int DATA_LINES   = DEF_DATA_LINES,
  parameter int BUCKET_SIZE  = DEF_BUCKET_SIZE,
  parameter int BUCKET_WIDTH = DEF_BUCKET_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [BUCKET_SIZE-1:0][BUCKET_WIDTH-1:0] data_in [DATA_LINES-1:0],
  input  logic [DATA_LINES-1:0][BUCKET_SIZE-1:0]   sel,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [BUCKET_WIDTH-1:0]                  out_data,
  output logic                                     out_hit,
  output logic [idx_w(DATA_LINES)-1:0]             out_line,
  output logic [idx_w(BUCKET_SIZE)-1:0]            out_slot,
  output logic                                     out_multi_hit,
  output logic [CNT_WIDTH-1:0]                     multi_hit_cnt
);

  localparam int LW = idx_w(DATA_LINES);
  localparam int SW = idx_w(BUCKET_SIZE);

  logic [DATA_LINES-1:0][BUCKET_WIDTH-1:0] ln_entry, s1_entry;
  logic [DATA_LINES-1:0]                   ln_hit, s1_hit;
  logic [DATA_LINES-1:0][SW-1:0]           ln_slot, s1_slot;
`ifdef HASH_BUCKET_MULTIHIT_CHECK_EN
  logic [DATA_LINES-1:0]                   ln_multi, s1_multi;
  logic                                    c_multi;
`endif

  for (genvar g = 0; g < DATA_LINES; g++) begin : g_line
    bucket_line_reduce #(
      .BUCKET_SIZE (BUCKET_SIZE),
      .BUCKET_WIDTH(BUCKET_WIDTH)
    ) u_line (
      .slots(data_in[g]),
      .sel  (sel[g]),
      .entry(ln_entry[g]),
      .hit  (ln_hit[g]),
`ifdef HASH_BUCKET_MULTIHIT_CHECK_EN
      .multi(ln_multi[g]),
`endif
      .slot (ln_slot[g])
    );
  end

  // vld_pipe[1] = stage 1 occupied, vld_pipe[2] = stage 2 / output occupied.
  logic [2:1] vld_pipe;
  logic       s1_adv, s2_adv;

  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign s1_adv    = !vld_pipe[1] || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = vld_pipe[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      if (s1_adv) vld_pipe[1] <= in_valid;
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_entry <= '0;
      s1_hit   <= '0;
      s1_slot  <= '0;
`ifdef HASH_BUCKET_MULTIHIT_CHECK_EN
      s1_multi <= '0;
`endif
    end else if (s1_adv && in_valid) begin
      s1_entry <= ln_entry;
      s1_hit   <= ln_hit;
      s1_slot  <= ln_slot;
`ifdef HASH_BUCKET_MULTIHIT_CHECK_EN
      s1_multi <= ln_multi;
`endif
    end
  end

  logic [BUCKET_WIDTH-1:0] c_data;
  logic                    c_hit;
  logic [LW-1:0]           c_line;
  logic [SW-1:0]           c_slot;

  always_comb begin
    c_hit  = |s1_hit;
    c_line = '0;
    c_slot = '0;
    c_data = '0;
    for (int l = DATA_LINES - 1; l >= 0; l--) begin
      if (s1_hit[l]) begin
        c_line = LW'(l);
        c_slot = s1_slot[l];
`ifdef HASH_BUCKET_MULTIHIT_CHECK_EN
        c_data = s1_entry[l];
`endif
      end
    end
`ifndef HASH_BUCKET_MULTIHIT_CHECK_EN
    // Non-hit lines carry a zero entry, so a plain OR is the legacy AND-OR.
    for (int l = 0; l < DATA_LINES; l++) begin
      c_data = c_data | s1_entry[l];
    end
`endif
  end

`ifdef HASH_BUCKET_MULTIHIT_CHECK_EN
  assign c_multi = (|s1_multi) || (|(s1_hit & (s1_hit - DATA_LINES'(1))));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= '0;
      out_hit  <= 1'b0;
      out_line <= '0;
      out_slot <= '0;
`ifdef HASH_BUCKET_MULTIHIT_CHECK_EN
      out_multi_hit <= 1'b0;
`endif
    end else if (s2_adv && vld_pipe[1]) begin
      out_data <= c_data;
      out_hit  <= c_hit;
      out_line <= c_line;
      out_slot <= c_slot;
`ifdef HASH_BUCKET_MULTIHIT_CHECK_EN
      out_multi_hit <= c_multi;
`endif
    end
  end

`ifdef HASH_BUCKET_MULTIHIT_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      multi_hit_cnt <= '0;
    end else if (out_valid && out_ready && out_multi_hit && !(&multi_hit_cnt)) begin
      multi_hit_cnt <= multi_hit_cnt + CNT_WIDTH'(1);
    end
  end
`else
  assign out_multi_hit = 1'b0;
  assign multi_hit_cnt = '0;
`endif

endmodule

// File: tb/tb_hash_bucket_select_pipe.sv
// Bench for hash_bucket_select_pipe: vector table, scoreboard, backpressure and reset cases.
// Expectations follow HASH_BUCKET_MULTIHIT_CHECK_EN when it is defined.
module tb_hash_bucket_select_pipe;

  localparam int DL = 4;
  localparam int BS = 2;
  localparam int BW = 16;
`ifdef HASH_BUCKET_MULTIHIT_CHECK_EN
  localparam bit MH = 1'b1;
`else
  localparam bit MH = 1'b0;
`endif

  typedef struct packed {
    logic [BW-1:0] data;
    logic          hit;
    logic [1:0]    line;
    logic          slot;
    logic          multi;
  } exp_t;

  typedef struct packed {
    logic [DL-1:0][BS-1:0][BW-1:0] din;
    logic [DL-1:0][BS-1:0]         sel;
    exp_t                          exp;
  } vec_t;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      in_valid, in_ready;
  logic [BS-1:0][BW-1:0]     data_in [DL-1:0];
  logic [DL-1:0][BS-1:0]     sel;
  logic                      out_valid, out_ready;
  logic [BW-1:0]             out_data;
  logic                      out_hit;
  logic [1:0]                out_line;
  logic                      out_slot;
  logic                      out_multi_hit;
  logic [15:0]               multi_hit_cnt;

  hash_bucket_select_pipe #(
    .DATA_LINES(DL), .BUCKET_SIZE(BS), .BUCKET_WIDTH(BW), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_hit(out_hit), .out_line(out_line), .out_slot(out_slot),
    .out_multi_hit(out_multi_hit), .multi_hit_cnt(multi_hit_cnt)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   deliveries = 0;
  int   exp_cnt = 0;
  exp_t q[$];
  exp_t cur_exp;
  exp_t prev_out;
  bit   prev_stall = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [DL-1:0][BS-1:0][BW-1:0] d,
                                 input logic [DL-1:0][BS-1:0] s);
    exp_t          e;
    int            n;
    logic [BW-1:0] orv;
    e = '0; n = 0; orv = '0;
    for (int l = 0; l < DL; l++)
      for (int k = 0; k < BS; k++)
        if (s[l][k]) begin
          if (n == 0) begin
            e.line = 2'(l);
            e.slot = 1'(k);
            e.data = d[l][k];
          end
          n++;
          orv = orv | d[l][k];
        end
    e.hit = (n > 0);
    if (!MH) e.data = orv;
    e.multi = MH && (n > 1);
    return e;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int l = 0; l < DL; l++)
      for (int k = 0; k < BS; k++) begin
        v.din[l][k] = 16'($urandom_range(1, 16'hFFFF));
        v.sel[l][k] = ($urandom_range(0, 3) == 0);
      end
    v.exp = model(v.din, v.sel);
    return v;
  endfunction

  task automatic apply(input vec_t v);
    for (int l = 0; l < DL; l++) data_in[l] = v.din[l];
    sel     = v.sel;
    cur_exp = v.exp;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send();
    bit r, ok;
    ok = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk) r = in_ready;
      @(posedge clk);
      #1;
      ok = r;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard: push on accept, pop and compare on delivery, watch stalled holds.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      chk("multi_hit_cnt", multi_hit_cnt, exp_cnt);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_out", {out_data, out_hit, out_line, out_slot, out_multi_hit}, prev_out);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_hit", out_hit, e.hit);
          chk("out_line", out_line, e.line);
          chk("out_slot", out_slot, e.slot);
          chk("out_multi_hit", out_multi_hit, e.multi);
          if (e.multi) exp_cnt++;
        end
        deliveries++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_data, out_hit, out_line, out_slot, out_multi_hit};
      if (in_valid && in_ready) q.push_back(cur_exp);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  vec_t vt[7];
  vec_t va, vb, vc;
  int   base;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel = '0; cur_exp = '0;
    for (int l = 0; l < DL; l++) data_in[l] = '0;

    // Table: hand-computed expectations for the documented cases.
    for (int i = 0; i < 7; i++) begin
      vt[i] = rand_vec();
      vt[i].sel = '0;
    end
    vt[0].sel[2][1] = 1'b1; vt[0].din[2][1] = 16'hBEEF;
    vt[0].exp = '{data: 16'hBEEF, hit: 1, line: 2, slot: 1, multi: 0};
    vt[1].exp = '{data: 16'h0000, hit: 0, line: 0, slot: 0, multi: 0};
    vt[2].sel[1][0] = 1'b1; vt[2].din[1][0] = 16'h00F0;
    vt[2].sel[3][1] = 1'b1; vt[2].din[3][1] = 16'h0F00;
    vt[2].exp = '{data: MH ? 16'h00F0 : 16'h0FF0, hit: 1, line: 1, slot: 0, multi: MH};
    vt[3].sel[0][0] = 1'b1; vt[3].din[0][0] = 16'h1234;
    vt[3].exp = '{data: 16'h1234, hit: 1, line: 0, slot: 0, multi: 0};
    vt[4].sel[3] = 2'b11; vt[4].din[3][0] = 16'h00AA; vt[4].din[3][1] = 16'h5500;
    vt[4].exp = '{data: MH ? 16'h00AA : 16'h55AA, hit: 1, line: 3, slot: 0, multi: MH};
    vt[5].sel = '1;
    for (int l = 0; l < DL; l++)
      for (int k = 0; k < BS; k++) vt[5].din[l][k] = 16'(1 << (2 * l + k));
    vt[5].exp = '{data: MH ? 16'h0001 : 16'h00FF, hit: 1, line: 0, slot: 0, multi: MH};
    vt[6].sel[0][1] = 1'b1; vt[6].din[0][1] = 16'h8001;
    vt[6].exp = '{data: 16'h8001, hit: 1, line: 0, slot: 1, multi: 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_hit", out_hit, 0);
    chk("rst_out_line", out_line, 0);
    chk("rst_out_slot", out_slot, 0);
    chk("rst_out_multi", out_multi_hit, 0);
    chk("rst_cnt", multi_hit_cnt, 0);
    reset = 1'b0;
    @(negedge clk) chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Isolated beats: each must show out_valid exactly two edges after accept.
    for (int i = 0; i < 7; i++) begin
      apply(vt[i]);
      send();
      chk("lat_early", out_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_2cyc", out_valid, 1);
      @(posedge clk);
      #1;
    end

    // Backpressure: A and B fill the pipe, C must wait while A is held.
    va = rand_vec(); vb = rand_vec(); vc = rand_vec();
    va.sel[1][1] = 1'b1; va.exp = model(va.din, va.sel);
    out_ready = 1'b0;
    apply(va); send();
    apply(vb); send();
    apply(vc); in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data_a", out_data, va.exp.data);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    base = deliveries;
    @(negedge clk) chk("bp_release_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("bp_three_in_row", deliveries, base + 3);
    @(negedge clk) chk("bp_drained", out_valid, 0);
    @(posedge clk);
    #1;

    // Random traffic with random consumer stalls.
    fork
      begin
        for (int c = 0; c < 300; c++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          apply(rand_vec());
          send();
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    chk("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;

    // Reset with both stages full discards everything at once.
    out_ready = 1'b0;
    apply(rand_vec()); send();
    apply(rand_vec()); send();
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_cnt", multi_hit_cnt, 0);
    q.delete();
    exp_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    apply(vt[2]);
    send();
    chk("post_rst_lat_early", out_valid, 0);
    @(posedge clk);
    #1;
    chk("post_rst_lat_2cyc", out_valid, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_cnt", multi_hit_cnt, MH ? 1 : 0);
    chk("final_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
